// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - CPU opcode map shared by the program loader and the control-unit decoder.
package cpu_isa_pkg;

  typedef enum logic [1:0] {
    KIND_LOADI = 2'd0,
    KIND_ALU   = 2'd1,
    KIND_J     = 2'd2,
    KIND_JZ    = 2'd3
  } kind_e;

  localparam logic [5:0] OPC_J     = 6'b001000;
  localparam logic [5:0] OPC_JZ    = 6'b001001;
  localparam logic [3:0] LOADI_PFX = 4'b0000;

  typedef enum logic [2:0] {
    ALU_A    = 3'b000,
    ALU_B    = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_NEGB = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENC  = 3'd1,
    ST_WR   = 3'd2,
    ST_VRD  = 3'd3,
    ST_VCMP = 3'd4
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [2:0]  alu_op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic [9:0]  addr;
  } instr_fields_t;

endpackage

// File: rtl/instr_enc.sv
// rtl/instr_enc.sv - combinational instruction-fields to 16-bit word encoder.
module instr_enc
  import cpu_isa_pkg::*;
(
  input  instr_fields_t fields_i,
  output logic [15:0]   word_o
);

  always_comb begin
    word_o = '0;
    unique case (fields_i.kind)
      KIND_LOADI: word_o = {LOADI_PFX, fields_i.imm, fields_i.rd};
      KIND_ALU:   word_o = {1'b1, fields_i.alu_op, fields_i.ra, fields_i.rb, fields_i.rd};
      KIND_J:     word_o = {OPC_J, fields_i.addr};
      KIND_JZ:    word_o = {OPC_JZ, fields_i.addr};
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// rtl/prog_encoder.sv - program-memory loader; PROG_VERIFY_EN adds a readback compare after each write.
module prog_encoder
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_alu_op,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [3:0]        in_rd,
  input  logic [7:0]        in_imm,
  input  logic [9:0]        in_addr,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  input  logic [15:0]       pm_rdata,
  output logic [10:0]       prog_len,
  output logic              full,
  output logic              busy,
  output logic              err_mismatch
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [10:0]       len_q;
  instr_fields_t     fields_q;
  instr_fields_t     fields_in;
  logic [15:0]       word_q;
  logic [15:0]       enc_word;
  logic              accept;

  assign fields_in = '{kind: kind_e'(in_kind), alu_op: in_alu_op, ra: in_ra, rb: in_rb,
                       rd: in_rd, imm: in_imm, addr: in_addr};

  instr_enc u_enc (
    .fields_i (fields_q),
    .word_o   (enc_word)
  );

  assign full     = (len_q == 11'(DEPTH));
  assign in_ready = (state_q == ST_IDLE) && !full && !clr;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  assign prog_len = len_q;
  assign pm_we    = (state_q == ST_WR);
  assign pm_addr  = addr_q;
  assign pm_wdata = word_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ENC;
      ST_ENC:  state_d = ST_WR;
`ifdef PROG_VERIFY_EN
      ST_WR:   state_d = ST_VRD;
`else
      ST_WR:   state_d = ST_IDLE;
`endif
      ST_VRD:  state_d = ST_VCMP;
      ST_VCMP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // addr_q is captured with the word so pm_addr holds the written address after wr_ptr moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      fields_q <= '0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) fields_q <= fields_in;
      if (state_q == ST_ENC) begin
        word_q <= enc_word;
        addr_q <= wr_ptr_q;
      end
      if (state_q == ST_WR) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        len_q    <= len_q + 1'b1;
      end
      if (state_q == ST_IDLE && clr) begin
        wr_ptr_q <= '0;
        len_q    <= '0;
      end
    end
  end

`ifdef PROG_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && clr) begin
      err_q <= 1'b0;
    end else if (state_q == ST_VCMP && pm_rdata != word_q) begin
      err_q <= 1'b1;
    end
  end

  assign err_mismatch = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^pm_rdata;
  assign err_mismatch = 1'b0;
`endif

endmodule
